// File: rtl/sampler_track_sequencer.sv
// Note-path sequencer for the sampler: live play, two-track record, and
// tick-timed playback that ORs both tracks onto one note vector.
module sampler_track_sequencer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NOTE_W = 5,
  parameter bit          LOOP   = 1'b0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [1:0]                 mode,
  input  logic [NOTE_W-1:0]          keys,
  input  logic                       key_stb,
  input  logic                       step_tick,
  output logic [NOTE_W-1:0]          note_out,
  output logic [$clog2(DEPTH+1)-1:0] len0,
  output logic [$clog2(DEPTH+1)-1:0] len1,
  output logic [1:0]                 full,
  output logic                       playing,
  output logic                       play_done
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_LIVE = 3'd0,
    S_REC0 = 3'd1,
    S_REC1 = 3'd2,
    S_PLAY = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_mode;
  logic [NOTE_W-1:0]   r_note, w_note_nxt;
  logic [LW-1:0]       r_idx, w_idx_nxt;
  logic [LW-1:0]       r_len0, w_len0_nxt;
  logic [LW-1:0]       r_len1, w_len1_nxt;
  logic [NOTE_W-1:0]   r_trk0 [DEPTH];
  logic [NOTE_W-1:0]   r_trk1 [DEPTH];
  logic                w_wr0, w_wr1;
  logic                w_keys_ok;
  logic                w_full0, w_full1;
  logic [LW-1:0]       w_play_len;
  logic [NOTE_W-1:0]   w_step0, w_step1, w_mix;

  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      2'b00:   return S_LIVE;
      2'b01:   return S_REC0;
      2'b10:   return S_REC1;
      default: return S_PLAY;
    endcase
  endfunction

  assign w_keys_ok  = $onehot(keys);
  assign w_full0    = (r_len0 == LW'(DEPTH));
  assign w_full1    = (r_len1 == LW'(DEPTH));
  assign w_play_len = (r_len0 > r_len1) ? r_len0 : r_len1;

  // Steps beyond a track's length read as silence so tracks of unequal length mix cleanly.
  assign w_step0 = (r_idx < r_len0) ? r_trk0[AW'(r_idx)] : '0;
  assign w_step1 = (r_idx < r_len1) ? r_trk1[AW'(r_idx)] : '0;
  assign w_mix   = w_step0 | w_step1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_LIVE;
      r_mode  <= 2'b00;
      r_note  <= '0;
      r_idx   <= '0;
      r_len0  <= '0;
      r_len1  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= mode;
      r_note  <= w_note_nxt;
      r_idx   <= w_idx_nxt;
      r_len0  <= w_len0_nxt;
      r_len1  <= w_len1_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_trk0 <= '{default: '0};
      r_trk1 <= '{default: '0};
    end else begin
      if (w_wr0) r_trk0[AW'(r_len0)] <= keys;
      if (w_wr1) r_trk1[AW'(r_len1)] <= keys;
    end
  end

  // A mode change pre-empts any strobe or tick arriving in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_note_nxt  = r_note;
    w_idx_nxt   = r_idx;
    w_len0_nxt  = r_len0;
    w_len1_nxt  = r_len1;
    w_wr0       = 1'b0;
    w_wr1       = 1'b0;
    if (mode != r_mode) begin
      w_state_nxt = mode_state(mode);
      w_note_nxt  = '0;
      w_idx_nxt   = '0;
      if (mode == 2'b01) w_len0_nxt = '0;
      if (mode == 2'b10) w_len1_nxt = '0;
    end else begin
      case (r_state)
        S_LIVE: begin
          if (key_stb) w_note_nxt = w_keys_ok ? keys : '0;
        end
        S_REC0: begin
          if (key_stb && w_keys_ok && !w_full0) begin
            w_wr0      = 1'b1;
            w_len0_nxt = r_len0 + LW'(1);
            w_note_nxt = keys;
          end
        end
        S_REC1: begin
          if (key_stb && w_keys_ok && !w_full1) begin
            w_wr1      = 1'b1;
            w_len1_nxt = r_len1 + LW'(1);
            w_note_nxt = keys;
          end
        end
        S_PLAY: begin
          if (w_play_len == '0) begin
            w_state_nxt = S_DONE;
            w_note_nxt  = '0;
          end else if (step_tick) begin
            // Index parks at the length after the last step so the final note lasts a full step.
            if (r_idx >= w_play_len) begin
              w_state_nxt = S_DONE;
              w_note_nxt  = '0;
              w_idx_nxt   = '0;
            end else begin
              w_note_nxt = w_mix;
              if (LOOP && (r_idx == w_play_len - LW'(1))) w_idx_nxt = '0;
              else                                        w_idx_nxt = r_idx + LW'(1);
            end
          end
        end
        S_DONE: begin
          w_note_nxt = '0;
        end
        default: begin
          w_state_nxt = S_LIVE;
          w_note_nxt  = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  assign note_out  = r_note;
  assign len0      = r_len0;
  assign len1      = r_len1;
  assign full      = {w_full1, w_full0};
  assign playing   = (r_state == S_PLAY);
  assign play_done = (r_state == S_DONE);

endmodule

// File: tb/tb_sampler_track_sequencer.sv
// Scoreboard bench: one-shot and looping sequencers share stimulus; a queue-based
// reference model predicts every cycle's outputs and a negedge monitor checks them.
module tb_sampler_track_sequencer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [4:0] keys = 5'd0;
  logic       key_stb = 1'b0;
  logic       step_tick = 1'b0;

  logic [4:0] note0, note1;
  logic [3:0] l00, l01, l10, l11;
  logic [1:0] f0, f1;
  logic       p0, p1, d0, d1;

  always #5 clk = ~clk;

  sampler_track_sequencer #(.DEPTH(DEPTH), .NOTE_W(5), .LOOP(1'b0)) u_once (
    .clk(clk), .resetn(resetn), .mode(mode), .keys(keys), .key_stb(key_stb),
    .step_tick(step_tick), .note_out(note0), .len0(l00), .len1(l01), .full(f0),
    .playing(p0), .play_done(d0));

  sampler_track_sequencer #(.DEPTH(DEPTH), .NOTE_W(5), .LOOP(1'b1)) u_loop (
    .clk(clk), .resetn(resetn), .mode(mode), .keys(keys), .key_stb(key_stb),
    .step_tick(step_tick), .note_out(note1), .len0(l10), .len1(l11), .full(f1),
    .playing(p1), .play_done(d1));

  typedef struct {
    logic [4:0] note;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] full;
    logic       playing;
    logic       done;
  } exp_t;

  exp_t sb0[$], sb1[$];
  exp_t me0, me1;
  int   n_checks = 0;
  int   n_err = 0;

  // Reference model: tracks as queues, playback as a precomputed list of mixed notes.
  localparam int M_LIVE = 0, M_REC0 = 1, M_REC1 = 2, M_PLAY = 3, M_DONE = 4;
  int         st [2];
  logic [4:0] mnote [2];
  int         nticks [2];
  logic [1:0] mprev;
  logic [4:0] t0[$], t1[$], pq[$];

  logic [4:0] rec_a [9];
  logic [1:0] rm;
  logic [4:0] rk;
  int         rlen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    t0.delete(); t1.delete(); pq.delete();
    mprev = 2'b00;
    for (int d = 0; d < 2; d++) begin
      st[d] = M_LIVE; mnote[d] = 5'd0; nticks[d] = 0;
    end
  endfunction

  function automatic void model_step(input logic [1:0] m, input logic [4:0] k,
                                     input logic s, input logic t);
    bit ok;
    bit hit0, hit1;
    int plen;
    ok = ($countones(k) == 1);
    if (m != mprev) begin
      if (m == 2'b01) t0.delete();
      if (m == 2'b10) t1.delete();
      if (m == 2'b11) begin
        pq.delete();
        plen = (t0.size() > t1.size()) ? t0.size() : t1.size();
        for (int i = 0; i < plen; i++)
          pq.push_back((i < t0.size() ? t0[i] : 5'd0) | (i < t1.size() ? t1[i] : 5'd0));
      end
      for (int d = 0; d < 2; d++) begin
        st[d] = int'(m); mnote[d] = 5'd0; nticks[d] = 0;
      end
    end else begin
      hit0 = (st[0] == M_REC0) && s && ok && (t0.size() < DEPTH);
      hit1 = (st[0] == M_REC1) && s && ok && (t1.size() < DEPTH);
      if (hit0) t0.push_back(k);
      if (hit1) t1.push_back(k);
      for (int d = 0; d < 2; d++) begin
        case (st[d])
          M_LIVE: if (s) mnote[d] = ok ? k : 5'd0;
          M_REC0: if (hit0) mnote[d] = k;
          M_REC1: if (hit1) mnote[d] = k;
          M_PLAY: begin
            if (pq.size() == 0) begin
              st[d] = M_DONE; mnote[d] = 5'd0;
            end else if (t) begin
              if (d == 1) begin
                mnote[d] = pq[nticks[d] % pq.size()];
                nticks[d]++;
              end else if (nticks[d] < pq.size()) begin
                mnote[d] = pq[nticks[d]];
                nticks[d]++;
              end else begin
                st[d] = M_DONE; mnote[d] = 5'd0;
              end
            end
          end
          default: mnote[d] = 5'd0;
        endcase
      end
    end
    mprev = m;
  endfunction

  function automatic exp_t mk(input int d);
    exp_t e;
    e.note    = mnote[d];
    e.len0    = 4'(t0.size());
    e.len1    = 4'(t1.size());
    e.full    = {t1.size() == DEPTH, t0.size() == DEPTH};
    e.playing = (st[d] == M_PLAY);
    e.done    = (st[d] == M_DONE);
    return e;
  endfunction

  task automatic cyc(input logic [1:0] m, input logic [4:0] k, input logic s, input logic t);
    exp_t e0, e1;
    mode = m; keys = k; key_stb = s; step_tick = t;
    model_step(m, k, s, t);
    e0 = mk(0);
    e1 = mk(1);
    @(posedge clk);
    sb0.push_back(e0);
    sb1.push_back(e1);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb0.size() > 0) begin
      me0 = sb0.pop_front();
      chk("once.note", 32'(note0), 32'(me0.note));
      chk("once.len0", 32'(l00), 32'(me0.len0));
      chk("once.len1", 32'(l01), 32'(me0.len1));
      chk("once.full", 32'(f0), 32'(me0.full));
      chk("once.playing", 32'(p0), 32'(me0.playing));
      chk("once.play_done", 32'(d0), 32'(me0.done));
    end
    if (sb1.size() > 0) begin
      me1 = sb1.pop_front();
      chk("loop.note", 32'(note1), 32'(me1.note));
      chk("loop.len0", 32'(l10), 32'(me1.len0));
      chk("loop.len1", 32'(l11), 32'(me1.len1));
      chk("loop.full", 32'(f1), 32'(me1.full));
      chk("loop.playing", 32'(p1), 32'(me1.playing));
      chk("loop.play_done", 32'(d1), 32'(me1.done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1);
  end

  initial begin
    rec_a = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001,
              5'b10000, 5'b01000, 5'b00100, 5'b00010};
    model_reset();
    #12;
    chk("rst.note", 32'(note0), 32'd0);
    chk("rst.len0", 32'(l00), 32'd0);
    chk("rst.len1", 32'(l01), 32'd0);
    chk("rst.full", 32'(f0), 32'd0);
    chk("rst.playing", 32'(p0), 32'd0);
    chk("rst.play_done", 32'(d1), 32'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    // Live play: valid one-hot echoes, a chord reads as silence.
    cyc(2'b00, 5'b00100, 1'b1, 1'b0);
    cyc(2'b00, 5'b00000, 1'b0, 1'b0);
    cyc(2'b00, 5'b00110, 1'b1, 1'b0);
    cyc(2'b00, 5'b00000, 1'b0, 1'b0);

    // Fill track 0 and overflow by one strobe.
    cyc(2'b01, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(2'b01, rec_a[i], 1'b1, 1'b0);
      cyc(2'b01, 5'b00000, 1'b0, 1'b0);
    end

    cyc(2'b10, 5'b00000, 1'b0, 1'b0);
    cyc(2'b10, 5'b00001, 1'b1, 1'b0);
    cyc(2'b10, 5'b00001, 1'b1, 1'b0);
    cyc(2'b10, 5'b00010, 1'b1, 1'b0);
    cyc(2'b10, 5'b00000, 1'b0, 1'b0);

    cyc(2'b11, 5'b00000, 1'b0, 1'b0);
    cyc(2'b11, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cyc(2'b11, 5'b00000, 1'b0, 1'b1);
      cyc(2'b11, 5'b00000, 1'b0, 1'b0);
      cyc(2'b11, 5'b00000, 1'b0, 1'b0);
    end

    // Empty both tracks, then play nothing.
    cyc(2'b00, 5'b00000, 1'b0, 1'b0);
    cyc(2'b01, 5'b00000, 1'b0, 1'b0);
    cyc(2'b10, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(2'b11, 5'b00000, 1'b0, 1'b1);

    // Two-step loop, then abort mid-step.
    cyc(2'b00, 5'b00000, 1'b0, 1'b0);
    cyc(2'b01, 5'b00000, 1'b0, 1'b0);
    cyc(2'b01, 5'b01000, 1'b1, 1'b0);
    cyc(2'b01, 5'b00010, 1'b1, 1'b0);
    cyc(2'b11, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 5'b00000, 1'b0, 1'b1);
      cyc(2'b11, 5'b00000, 1'b0, 1'b0);
    end
    cyc(2'b00, 5'b00000, 1'b0, 1'b1);
    cyc(2'b00, 5'b00000, 1'b0, 1'b0);

    for (int seg = 0; seg < 70; seg++) begin
      rm = 2'($urandom_range(0, 3));
      rlen = $urandom_range(1, 40);
      for (int c = 0; c < rlen; c++) begin
        if ($urandom_range(0, 4) != 0) rk = 5'(32'd1 << $urandom_range(0, 4));
        else                           rk = 5'($urandom);
        cyc(rm, rk, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      end
    end

    // Asynchronous reset in the middle of recording.
    cyc(2'b00, 5'b00000, 1'b0, 1'b0);
    cyc(2'b01, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(2'b01, rec_a[i], 1'b1, 1'b0);
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("async.len0", 32'(l00), 32'd0);
    chk("async.note", 32'(note0), 32'd0);
    chk("async.full", 32'(f1), 32'd0);
    model_reset();
    mode = 2'b00; keys = 5'd0; key_stb = 1'b0; step_tick = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    cyc(2'b00, 5'b00000, 1'b0, 1'b0);
    cyc(2'b00, 5'b10000, 1'b1, 1'b0);
    cyc(2'b11, 5'b00000, 1'b0, 1'b1);
    cyc(2'b11, 5'b00000, 1'b0, 1'b1);
    cyc(2'b11, 5'b00000, 1'b0, 1'b0);

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
